mux_n_1_pipe_v: RTL

MUX_N_1_PIPE_V -- requirements
Module: mux_n_1_pipe_v

---
 rtl/mux_pkg.sv | 22 ++
 rtl/mux_n_1_comb_v.sv | 22 ++
 rtl/mux_n_1_pipe_v.sv | 96 +++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared defaults, select-width helper and output-stage state type for the
// pipelined N:1 multiplexer.
package mux_pkg;

    localparam int DEF_N_CH = 8;
    localparam int DEF_W    = 1;

    // Ceiling log2, with a minimum of 1 so a 1-bit select always exists.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

endpackage

// File: rtl/mux_n_1_comb_v.sv
// Purely combinational N_CH:1 selector over a packed channel bus;
// channel k sits at bits [k*W +: W].
module mux_n_1_comb_v
    import mux_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int W     = DEF_W,
    localparam int SEL_W = clog2(N_CH)
) (
    input  logic [N_CH*W-1:0] code,
    input  logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      f
);

    always_comb begin
        f = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) f = code[k*W +: W];
        end
    end

endmodule

// File: rtl/mux_n_1_pipe_v.sv
// Pipelined N_CH:1 multiplexer with a one-deep valid/ready output stage.
// Optional scan mode (auto-incrementing select) is built with MUX_N_1_PIPE_SCAN_EN.
module mux_n_1_pipe_v
    import mux_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int W     = DEF_W,
    localparam int SEL_W = clog2(N_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [N_CH*W-1:0] i_code,
    input  logic [SEL_W-1:0]  i_sel_code,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [W-1:0]      o_f,
    output logic [SEL_W-1:0]  o_sel_code,
    output logic              o_valid,
    input  logic              i_ready,
    input  logic              i_scan
);

    // Handshake: a sample transfers on an edge where i_valid & o_ready; the
    // output sample transfers downstream on an edge where o_valid & i_ready.
    stage_state_t     state, state_nxt;
    logic             accept;
    logic [SEL_W-1:0] sel;
    logic [W-1:0]     sel_data;

`ifdef MUX_N_1_PIPE_SCAN_EN
    logic [SEL_W-1:0] scan_cnt;
    logic             scan_q;
    logic             scan_rise;

    assign scan_rise = i_scan & ~scan_q;
    // On the rising cycle the counter is being reloaded, so channel 0 is used directly.
    assign sel = i_scan ? (scan_rise ? '0 : scan_cnt) : i_sel_code;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scan_cnt <= '0;
            scan_q   <= 1'b0;
        end else begin
            scan_q <= i_scan;
            if (scan_rise) begin
                scan_cnt <= accept ? SEL_W'(1) : '0;
            end else if (i_scan && accept) begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_scan;
    assign unused_scan = i_scan;
    assign sel = i_sel_code;
`endif

    assign o_valid = (state == ST_FULL);
    assign o_ready = i_rst_n & i_en & (~o_valid | i_ready);
    assign accept  = i_valid & o_ready;

    mux_n_1_comb_v #(
        .N_CH (N_CH),
        .W    (W)
    ) u_comb (
        .code (i_code),
        .sel  (sel),
        .f    (sel_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_EMPTY;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_FULL;
            ST_FULL:  if (!accept && i_ready) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_f        <= '0;
            o_sel_code <= '0;
        end else if (accept) begin
            o_f        <= sel_data;
            o_sel_code <= sel;
        end
    end

endmodule
